// File: rtl/float64_to_float32_if.sv
// AXI-Stream bundle for the binary64 -> binary32 narrowing stage.
// The slave modport is the stage's own view; master is the upstream/downstream driver view.
interface float64_to_float32_if;
  logic [63:0] s_axis_a_tdata;
  logic        s_axis_a_tvalid;
  logic        s_axis_a_tready;
  logic [31:0] m_axis_result_tdata;
  logic [1:0]  m_axis_result_tuser;
  logic        m_axis_result_tvalid;
  logic        m_axis_result_tready;

  modport slave (
    input  s_axis_a_tdata,
    input  s_axis_a_tvalid,
    output s_axis_a_tready,
    output m_axis_result_tdata,
    output m_axis_result_tuser,
    output m_axis_result_tvalid,
    input  m_axis_result_tready
  );

  modport master (
    output s_axis_a_tdata,
    output s_axis_a_tvalid,
    input  s_axis_a_tready,
    input  m_axis_result_tdata,
    input  m_axis_result_tuser,
    input  m_axis_result_tvalid,
    output m_axis_result_tready
  );
endinterface

// File: rtl/float64_to_float32.sv
// Global-stall pipelined binary64 -> binary32 converter: capture, classify, round, output register.
// tuser[1] flags finite-to-infinity overflow, tuser[0] flags a nonzero input flushed to zero.
module float64_to_float32 #(
  parameter int ROUND_MODE = 0,
  parameter int LATENCY    = 3
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  float64_to_float32_if.slave  bus
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("float64_to_float32: LATENCY must be 3");
  end

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_ZERO = 3'd1,
    CLS_INF  = 3'd2,
    CLS_NAN  = 3'd3,
    CLS_OVF  = 3'd4
  } cls_e;

  logic        advance_s;

  logic        v0_q, v0_d;
  logic [63:0] d0_q, d0_d;

  logic        v1_q, v1_d;
  logic        sign1_q, sign1_d;
  cls_e        cls1_q, cls1_d;
  logic        uf1_q, uf1_d;
  logic [7:0]  exp1_q, exp1_d;
  logic [51:0] man1_q, man1_d;

  logic        v2_q, v2_d;
  logic [31:0] res2_q, res2_d;
  logic [1:0]  usr2_q, usr2_d;

  logic        v3_q, v3_d;
  logic [31:0] res3_q, res3_d;
  logic [1:0]  usr3_q, usr3_d;

  logic [10:0]        exp_in_s;
  logic [51:0]        man_in_s;
  logic signed [12:0] ebias_s;
  cls_e               cls_s;
  logic               uf_s;

  logic [22:0] mant_hi_s;
  logic        round_up_s;
  logic [30:0] sum_s;
  logic [31:0] res_s;
  logic [1:0]  usr_s;

  assign advance_s                = bus.m_axis_result_tready | ~v3_q;
  assign bus.s_axis_a_tready      = advance_s;
  assign bus.m_axis_result_tvalid = v3_q;
  assign bus.m_axis_result_tdata  = res3_q;
  assign bus.m_axis_result_tuser  = usr3_q;

  // Stage 0: raw capture of the incoming beat (bubbles included).
  always_comb begin
    v0_d = v0_q;
    d0_d = d0_q;
    if (advance_s) begin
      v0_d = bus.s_axis_a_tvalid;
      d0_d = bus.s_axis_a_tdata;
    end else begin
      v0_d = v0_q;
      d0_d = d0_q;
    end
  end

  assign exp_in_s = d0_q[62:52];
  assign man_in_s = d0_q[51:0];
  assign ebias_s  = $signed({2'b00, exp_in_s}) - 13'sd896;

  // Stage 1 classification of the captured operand.
  always_comb begin
    cls_s = CLS_NORM;
    uf_s  = 1'b0;
    if (exp_in_s == 11'h7FF) begin
      cls_s = (man_in_s != 52'd0) ? CLS_NAN : CLS_INF;
    end else if (exp_in_s == 11'h000) begin
      cls_s = CLS_ZERO;
      uf_s  = (man_in_s != 52'd0);
    end else if (ebias_s <= 13'sd0) begin
      cls_s = CLS_ZERO;
      uf_s  = 1'b1;
    end else if (ebias_s >= 13'sd255) begin
      cls_s = CLS_OVF;
    end else begin
      cls_s = CLS_NORM;
    end
  end

  // Stage 1 register inputs.
  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    cls1_d  = cls1_q;
    uf1_d   = uf1_q;
    exp1_d  = exp1_q;
    man1_d  = man1_q;
    if (advance_s) begin
      v1_d    = v0_q;
      sign1_d = d0_q[63];
      cls1_d  = cls_s;
      uf1_d   = uf_s;
      exp1_d  = ebias_s[7:0];
      man1_d  = man_in_s;
    end else begin
      v1_d    = v1_q;
      sign1_d = sign1_q;
      cls1_d  = cls1_q;
      uf1_d   = uf1_q;
      exp1_d  = exp1_q;
      man1_d  = man1_q;
    end
  end

  assign mant_hi_s  = man1_q[51:29];
  assign round_up_s = (ROUND_MODE == 32'sd0) && man1_q[28] && ((|man1_q[27:0]) || mant_hi_s[0]);
  // Exponent and mantissa add as one field so a mantissa carry bumps the exponent.
  assign sum_s      = {exp1_q, mant_hi_s} + {30'd0, round_up_s};

  // Stage 2: pack the binary32 result and flags.
  always_comb begin
    res_s = 32'd0;
    usr_s = 2'b00;
    case (cls1_q)
      CLS_NAN: begin
        res_s = {sign1_q, 8'hFF, 1'b1, man1_q[50:29]};
        usr_s = 2'b00;
      end
      CLS_INF: begin
        res_s = {sign1_q, 8'hFF, 23'd0};
        usr_s = 2'b00;
      end
      CLS_ZERO: begin
        res_s = {sign1_q, 31'd0};
        usr_s = {1'b0, uf1_q};
      end
      CLS_OVF: begin
        res_s = {sign1_q, 8'hFF, 23'd0};
        usr_s = 2'b10;
      end
      CLS_NORM: begin
        if (sum_s[30:23] == 8'hFF) begin
          res_s = {sign1_q, 8'hFF, 23'd0};
          usr_s = 2'b10;
        end else begin
          res_s = {sign1_q, sum_s};
          usr_s = 2'b00;
        end
      end
      default: begin
        res_s = 32'd0;
        usr_s = 2'b00;
      end
    endcase
  end

  // Stage 2 and stage 3 register inputs.
  always_comb begin
    v2_d   = v2_q;
    res2_d = res2_q;
    usr2_d = usr2_q;
    v3_d   = v3_q;
    res3_d = res3_q;
    usr3_d = usr3_q;
    if (advance_s) begin
      v2_d   = v1_q;
      res2_d = res_s;
      usr2_d = usr_s;
      v3_d   = v2_q;
      res3_d = res2_q;
      usr3_d = usr2_q;
    end else begin
      v2_d   = v2_q;
      res2_d = res2_q;
      usr2_d = usr2_q;
      v3_d   = v3_q;
      res3_d = res3_q;
      usr3_d = usr3_q;
    end
  end

  // Pipeline state; reset discards in-flight beats and clears data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v0_q    <= 1'b0;
      d0_q    <= 64'd0;
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      cls1_q  <= CLS_ZERO;
      uf1_q   <= 1'b0;
      exp1_q  <= 8'd0;
      man1_q  <= 52'd0;
      v2_q    <= 1'b0;
      res2_q  <= 32'd0;
      usr2_q  <= 2'b00;
      v3_q    <= 1'b0;
      res3_q  <= 32'd0;
      usr3_q  <= 2'b00;
    end else begin
      v0_q    <= v0_d;
      d0_q    <= d0_d;
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      cls1_q  <= cls1_d;
      uf1_q   <= uf1_d;
      exp1_q  <= exp1_d;
      man1_q  <= man1_d;
      v2_q    <= v2_d;
      res2_q  <= res2_d;
      usr2_q  <= usr2_d;
      v3_q    <= v3_d;
      res3_q  <= res3_d;
      usr3_q  <= usr3_d;
    end
  end

endmodule

// File: tb/tb_float64_to_float32.sv
// Self-checking bench: two instances (round-to-nearest-even and truncate) share one stimulus
// stream; a numeric reference model feeds per-instance scoreboards checked every cycle.
module tb_float64_to_float32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [63:0] drv_data;
  logic        drv_valid;
  logic        drv_mready;

  float64_to_float32_if if_rne ();
  float64_to_float32_if if_trn ();

  assign if_rne.s_axis_a_tdata       = drv_data;
  assign if_rne.s_axis_a_tvalid      = drv_valid;
  assign if_rne.m_axis_result_tready = drv_mready;
  assign if_trn.s_axis_a_tdata       = drv_data;
  assign if_trn.s_axis_a_tvalid      = drv_valid;
  assign if_trn.m_axis_result_tready = drv_mready;

  float64_to_float32 #(.ROUND_MODE(0), .LATENCY(3)) dut_rne (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (if_rne.slave)
  );

  float64_to_float32 #(.ROUND_MODE(1), .LATENCY(3)) dut_trn (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (if_trn.slave)
  );

  int checks = 0;
  int failures = 0;
  longint edge_cnt = 0;

  logic [33:0] exp_q [2][$];
  longint      acc_q [2][$];
  bit          seen [2];
  bit          prev_stall [2];
  bit          chk_lat;

  typedef struct {
    logic [63:0] x;
    logic [33:0] er;
    logic [33:0] et;
  } vec_t;
  vec_t vecs [16];

  always @(posedge aclk) edge_cnt <= edge_cnt + 64'sd1;

  // Reference conversion from the numeric value: 24-bit significand, integer rounding, renormalise.
  function automatic logic [33:0] model(input logic [63:0] x, input int mode);
    logic   s;
    int     ex;
    longint sig, q, r, half;
    s  = x[63];
    ex = int'(x[62:52]) - 896;
    if (x[62:52] == 11'h7FF) begin
      if (x[51:0] != 52'd0) return {2'b00, s, 8'hFF, 1'b1, x[50:29]};
      return {2'b00, s, 8'hFF, 23'd0};
    end
    if (x[62:52] == 11'h000) return {1'b0, (x[51:0] != 52'd0), s, 31'd0};
    if (ex <= 0) return {2'b01, s, 31'd0};
    if (ex >= 255) return {2'b10, s, 8'hFF, 23'd0};
    sig  = longint'({1'b1, x[51:0]});
    q    = sig >> 29;
    r    = sig - (q << 29);
    half = longint'(1) << 28;
    if (mode == 0 && (r > half || (r == half && (q % 2) == 1))) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {2'b10, s, 8'hFF, 23'd0};
    return {2'b00, s, ex[7:0], q[22:0]};
  endfunction

  task automatic mon(input int id, input logic sv, input logic sr, input logic [63:0] sd,
                     input logic mv, input logic mr, input logic [31:0] md, input logic [1:0] mu);
    logic [33:0] e;
    checks++;
    if (sr !== (mr | ~mv)) begin
      failures++;
      $display("FAIL s_tready[%0d]: got %b want %b", id, sr, (mr | ~mv));
    end
    if (prev_stall[id]) begin
      checks++;
      if (mv !== 1'b1) begin
        failures++;
        $display("FAIL hold_valid[%0d]: tvalid dropped while stalled", id);
      end
    end
    if (mv) begin
      if (exp_q[id].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_output[%0d]: got %h/%b with nothing expected", id, md, mu);
      end else begin
        e = exp_q[id][0];
        checks++;
        if ({mu, md} !== e) begin
          failures++;
          $display("FAIL result[%0d]: got tdata=%h tuser=%b want tdata=%h tuser=%b",
                   id, md, mu, e[31:0], e[33:32]);
        end
        if (!seen[id] && chk_lat) begin
          checks++;
          if (edge_cnt - acc_q[id][0] != 64'sd3) begin
            failures++;
            $display("FAIL latency[%0d]: got %0d cycles want 3", id, edge_cnt - acc_q[id][0]);
          end
        end
        seen[id] = 1'b1;
        if (mr) begin
          void'(exp_q[id].pop_front());
          void'(acc_q[id].pop_front());
          seen[id] = 1'b0;
        end
      end
    end
    prev_stall[id] = mv & ~mr;
    if (sv & sr) begin
      exp_q[id].push_back(model(sd, id));
      acc_q[id].push_back(edge_cnt + 64'sd1);
    end
  endtask

  // Per-cycle compare of both instances, sampled away from the active edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      mon(0, drv_valid, if_rne.s_axis_a_tready, drv_data, if_rne.m_axis_result_tvalid,
          drv_mready, if_rne.m_axis_result_tdata, if_rne.m_axis_result_tuser);
      mon(1, drv_valid, if_trn.s_axis_a_tready, drv_data, if_trn.m_axis_result_tvalid,
          drv_mready, if_trn.m_axis_result_tdata, if_trn.m_axis_result_tuser);
    end
  end

  task automatic send(input logic [63:0] x);
    bit acc;
    acc = 1'b0;
    drv_data  = x;
    drv_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge aclk);
      acc = if_rne.s_axis_a_tready;
      @(posedge aclk);
      #1;
    end
    drv_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: beat %h never accepted", x);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      failures++;
      $display("FAIL drain: %0d/%0d results missing", exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (if_rne.m_axis_result_tvalid !== 1'b0 || if_rne.m_axis_result_tdata !== 32'd0 ||
        if_rne.m_axis_result_tuser !== 2'b00 || if_trn.m_axis_result_tvalid !== 1'b0 ||
        if_trn.m_axis_result_tdata !== 32'd0 || if_trn.m_axis_result_tuser !== 2'b00) begin
      failures++;
      $display("FAIL %s: got valid=%b/%b data=%h/%h want 0", tag,
               if_rne.m_axis_result_tvalid, if_trn.m_axis_result_tvalid,
               if_rne.m_axis_result_tdata, if_trn.m_axis_result_tdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{64'h3FF0000000000000, {2'b00, 32'h3F800000}, {2'b00, 32'h3F800000}};
    vecs[1]  = '{64'hC000000000000000, {2'b00, 32'hC0000000}, {2'b00, 32'hC0000000}};
    vecs[2]  = '{64'h3FF0000010000000, {2'b00, 32'h3F800000}, {2'b00, 32'h3F800000}};
    vecs[3]  = '{64'h3FF0000030000000, {2'b00, 32'h3F800002}, {2'b00, 32'h3F800001}};
    vecs[4]  = '{64'h3FF0000010000001, {2'b00, 32'h3F800001}, {2'b00, 32'h3F800000}};
    vecs[5]  = '{64'h47F0000000000000, {2'b10, 32'h7F800000}, {2'b10, 32'h7F800000}};
    vecs[6]  = '{64'h47EFFFFFF0000000, {2'b10, 32'h7F800000}, {2'b00, 32'h7F7FFFFF}};
    vecs[7]  = '{64'h7FF0000000000000, {2'b00, 32'h7F800000}, {2'b00, 32'h7F800000}};
    vecs[8]  = '{64'h3800000000000000, {2'b01, 32'h00000000}, {2'b01, 32'h00000000}};
    vecs[9]  = '{64'hB800000000000000, {2'b01, 32'h80000000}, {2'b01, 32'h80000000}};
    vecs[10] = '{64'h8000000000000000, {2'b00, 32'h80000000}, {2'b00, 32'h80000000}};
    vecs[11] = '{64'h7FF0000000000001, {2'b00, 32'h7FC00000}, {2'b00, 32'h7FC00000}};
    vecs[12] = '{64'h7FF8000000000000, {2'b00, 32'h7FC00000}, {2'b00, 32'h7FC00000}};
    vecs[13] = '{64'h0000000000000001, {2'b01, 32'h00000000}, {2'b01, 32'h00000000}};
    vecs[14] = '{64'h3810000000000000, {2'b00, 32'h00800000}, {2'b00, 32'h00800000}};
    vecs[15] = '{64'hFFF4000000000000, {2'b00, 32'hFFE00000}, {2'b00, 32'hFFE00000}};

    drv_data   = 64'd0;
    drv_valid  = 1'b0;
    drv_mready = 1'b1;
    chk_lat    = 1'b1;

    // Hand-computed values pin the reference model before it is trusted.
    foreach (vecs[i]) begin
      checks++;
      if (model(vecs[i].x, 0) !== vecs[i].er || model(vecs[i].x, 1) !== vecs[i].et) begin
        failures++;
        $display("FAIL model_pin[%0d]: got %h/%h want %h/%h", i,
                 model(vecs[i].x, 0), model(vecs[i].x, 1), vecs[i].er, vecs[i].et);
      end
    end

    #12;
    check_idle("reset_state");
    checks++;
    if (if_rne.s_axis_a_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready: got %b want 1", if_rne.s_axis_a_tready);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Directed vectors, back to back, no stall: value and 3-cycle latency.
    foreach (vecs[i]) send(vecs[i].x);
    drain();

    // Backpressure: 8 continuous beats, tready low for cycles 4..7 then toggling.
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i + 2].x);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          drv_mready = (c < 4) ? 1'b1 : (c < 8) ? 1'b0 : ((c % 2) == 0);
          @(posedge aclk);
          #1;
        end
        drv_mready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: one result at the output, three more in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 4; i++) send(vecs[i].x);
    checks++;
    if (if_rne.m_axis_result_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b want 1", if_rne.m_axis_result_tvalid);
    end
    #1;
    aresetn = 1'b0;
    #1;
    check_idle("async_reset");
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      acc_q[k].delete();
      seen[k]       = 1'b0;
      prev_stall[k] = 1'b0;
    end
    #1;
    aresetn = 1'b1;
    send(vecs[6].x);
    send(vecs[15].x);
    drain();

    repeat (3) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
